// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding and counter-width helpers.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W     = $clog2(WIDTH_DEF);

    // Bit-counter width for a given operand width (WIDTH >= 2).
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_fulladder.sv
// Combinational one-bit full adder cell used as the serial datapath.
// Ports: sum/carry out; op1/op2/op3 in.
module fullAdder (
    output logic sum,
    output logic carry,
    input  logic op1,
    input  logic op2,
    input  logic op3
);

    assign sum   = op1 ^ op2 ^ op3;
    assign carry = (op1 & op2) | (op1 & op3) | (op2 & op3);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: parallel load, LSB-first add, parallel result.
// Ports: clk, rst_n, start, a, b, cin in; busy, done, sum, cout out.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] r_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_c;
    logic             load;
    logic             last;
    logic [WIDTH-1:0] r_nx;

    fullAdder u_fa (
        .sum   (fa_s),
        .carry (fa_c),
        .op1   (a_sh[0]),
        .op2   (b_sh[0]),
        .op3   (carry)
    );

    // start is only honoured when no add is in flight.
    assign load = start & ((state == IDLE) | (state == DONE));
    assign last = (state == RUN) & (cnt == CW'(WIDTH - 1));

    // New bit enters at the MSB; the oldest partial bit drops out
    // of r_sh but lands in sum[0] on the completing edge.
    assign r_nx = {fa_s, r_sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                state_nx = start ? RUN : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            r_sh  <= r_nx[WIDTH-1:1];
            carry <= fa_c;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= r_nx;
                cout <= fa_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder with WIDTH=8.
// Directed scenarios plus random operands against a+b+cin.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int vectors;
    int miscompares;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Called 1 time unit after a rising edge; returns with the
    // bench sitting 1 unit after the edge where done went high.
    task automatic do_add(
        input  logic [7:0] av,
        input  logic [7:0] bv,
        input  logic       ci,
        output logic [7:0] s,
        output logic       co,
        output int         lat,
        output int         bc
    );
        logic got;
        a = av;
        b = bv;
        cin = ci;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'hxx;
        b = 8'hxx;
        cin = 1'bx;
        lat = 0;
        bc = 0;
        got = 1'b0;
        s = 8'hxx;
        co = 1'bx;
        while (!got && lat < 20) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            lat++;
            if (done) begin
                got = 1'b1;
                s = sum;
                co = cout;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        cin = 1'b0;
        #2;
        vectors++;
        if ({busy, done, sum, cout} !== 11'h000) begin
            miscompares++;
            $display("FAIL reset: busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
                     busy, done, sum, cout);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({busy, done, sum, cout} !== 11'h000) begin
                miscompares++;
                $display("FAIL idle%0d: busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
                         i, busy, done, sum, cout);
            end
        end
    endtask

    task automatic test_basic;
        logic [7:0] s;
        logic       co;
        int         lat;
        int         bc;
        do_add(8'h35, 8'h4A, 1'b0, s, co, lat, bc);
        vectors++;
        if ({co, s} !== 9'h07F) begin
            miscompares++;
            $display("FAIL basic_sum: got %b_%h want 0_7f", co, s);
        end
        vectors++;
        if (lat !== 8) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d edges want 8", lat);
        end
        vectors++;
        if (bc !== 8) begin
            miscompares++;
            $display("FAIL basic_busy: got %0d cycles want 8", bc);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy_in_done: got %b want 0", busy);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({done, busy, cout, sum} !== 11'h07F) begin
            miscompares++;
            $display("FAIL basic_pulse_hold: done=%b busy=%b sum=%b_%h want 0 0 0_7f",
                     done, busy, cout, sum);
        end
    endtask

    task automatic test_ripple;
        logic [7:0] s;
        logic       co;
        int         lat;
        int         bc;
        do_add(8'hFF, 8'h01, 1'b1, s, co, lat, bc);
        vectors++;
        if ({co, s} !== 9'h101) begin
            miscompares++;
            $display("FAIL ripple: got %b_%h want 1_01", co, s);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        logic [7:0] s;
        logic       co;
        int         lat;
        int         bc;
        do_add(8'h01, 8'h02, 1'b0, s, co, lat, bc);
        vectors++;
        if ({co, s} !== 9'h003) begin
            miscompares++;
            $display("FAIL b2b_first: got %b_%h want 0_03", co, s);
        end
        do_add(8'h80, 8'h80, 1'b0, s, co, lat, bc);
        vectors++;
        if ({co, s} !== 9'h100) begin
            miscompares++;
            $display("FAIL b2b_second: got %b_%h want 1_00", co, s);
        end
        vectors++;
        if (lat !== 8) begin
            miscompares++;
            $display("FAIL b2b_latency: got %0d edges want 8", lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mid_start;
        int         ndone;
        logic [7:0] s;
        logic       co;
        ndone = 0;
        s = 8'hxx;
        co = 1'bx;
        a = 8'h10;
        b = 8'h20;
        cin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin
                start = 1'b1;
                a = 8'hFF;
                b = 8'hFF;
                cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                s = sum;
                co = cout;
            end
        end
        vectors++;
        if (ndone !== 1) begin
            miscompares++;
            $display("FAIL mid_start_count: got %0d done pulses want 1", ndone);
        end
        vectors++;
        if ({co, s} !== 9'h030) begin
            miscompares++;
            $display("FAIL mid_start_sum: got %b_%h want 0_30", co, s);
        end
    endtask

    task automatic test_reset_abort;
        int         ndone;
        logic [7:0] s;
        logic       co;
        int         lat;
        int         bc;
        ndone = 0;
        a = 8'h5A;
        b = 8'h33;
        cin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, sum, cout} !== 11'h000) begin
            miscompares++;
            $display("FAIL abort_reset: busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
                     busy, done, sum, cout);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        vectors++;
        if (ndone !== 0) begin
            miscompares++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", ndone);
        end
        do_add(8'h5A, 8'h33, 1'b0, s, co, lat, bc);
        vectors++;
        if ({co, s} !== 9'h08D) begin
            miscompares++;
            $display("FAIL abort_recover: got %b_%h want 0_8d", co, s);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        logic [7:0] av;
        logic [7:0] bv;
        logic       ci;
        logic [8:0] want;
        logic [7:0] s;
        logic       co;
        int         lat;
        int         bc;
        for (int i = 0; i < 1000; i++) begin
            av = 8'($urandom_range(0, 255));
            bv = 8'($urandom_range(0, 255));
            ci = 1'($urandom_range(0, 1));
            want = {1'b0, av} + {1'b0, bv} + {8'h00, ci};
            do_add(av, bv, ci, s, co, lat, bc);
            vectors++;
            if ({co, s} !== want || lat !== 8) begin
                miscompares++;
                $display("FAIL rand%0d: %h+%h+%b got %b_%h lat %0d want %b_%h lat 8",
                         i, av, bv, ci, co, s, lat, want[8], want[7:0]);
            end
            if ((i % 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset;
        test_basic;
        test_ripple;
        test_back_to_back;
        test_mid_start;
        test_reset_abort;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
